// File: rtl/calib_window_scheduler_if.sv
// ---------------------------------------------------------------------------
// calib_window_scheduler_if
//
// Bundles the control inputs and status outputs of the calibration window
// scheduler. The scheduler connects through the slave modport. The trigger
// board control logic, or a bench, drives the master side.
//
// Signals:
//   clk_locked   master->slave  PLL lock; low aborts and holds the scheduler
//   calibticks   master->slave  period control, sampled at window start
//   force_cal    master->slave  single-cycle request to start a window now
//   delaycounter master->slave  per-channel 3-bit lock result, 0 = no lock
//   spareleft    slave->master  calibration window active
//   capture_en   slave->master  capture phase of the window
//   cal_done     slave->master  one-cycle pulse in EVAL
//   lock_mask    slave->master  per-channel lock result of the last EVAL
//   all_locked   slave->master  lock_mask is all ones
//   cal_count    slave->master  completed evaluations, saturating
//   fail_count   slave->master  evaluations with a missing lock, saturating
// ---------------------------------------------------------------------------
interface calib_window_scheduler_if #(
    parameter int NCH = 16
) ();
    logic               clk_locked;
    logic [7:0]         calibticks;
    logic               force_cal;
    logic [NCH*3-1:0]   delaycounter;

    logic               spareleft;
    logic               capture_en;
    logic               cal_done;
    logic [NCH-1:0]     lock_mask;
    logic               all_locked;
    logic [15:0]        cal_count;
    logic [15:0]        fail_count;

    modport master (
        output clk_locked, calibticks, force_cal, delaycounter,
        input  spareleft, capture_en, cal_done, lock_mask, all_locked,
               cal_count, fail_count
    );

    modport slave (
        input  clk_locked, calibticks, force_cal, delaycounter,
        output spareleft, capture_en, cal_done, lock_mask, all_locked,
               cal_count, fail_count
    );
endinterface

// File: rtl/calib_window_scheduler.sv
// ---------------------------------------------------------------------------
// calib_window_scheduler
//
// Sequences the periodic sync-pulse calibration of the trigger-input delay
// lock. Each window has a quiet phase, which lets normal triggers drain, and
// then a capture phase. After the window, one EVAL cycle latches the
// per-channel delaycounter results and updates the statistics. A failed
// evaluation is retried immediately, up to MAX_RETRY times. Windows repeat
// every 2^E cycles, where E = min(BASE_EXP + calibticks, 31).
//
// Ports:
//   clk_adc  in   sole clock, rising edge
//   rst      in   asynchronous, active-high reset
//   bus      slave modport of calib_window_scheduler_if (see that file)
// ---------------------------------------------------------------------------
module calib_window_scheduler #(
    parameter int NCH          = 16,
    parameter int QUIET_TICKS  = 200,
    parameter int WINDOW_TICKS = 655,
    parameter int MAX_RETRY    = 2,
    parameter int BASE_EXP     = 17
) (
    input  logic                     clk_adc,
    input  logic                     rst,
    calib_window_scheduler_if.slave  bus
);

    localparam int W_W  = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
    localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [W_W-1:0]  W_LAST  = W_W'(WINDOW_TICKS - 1);
    localparam logic [W_W-1:0]  W_QUIET = W_W'(QUIET_TICKS);
    localparam logic [RC_W-1:0] RC_MAX  = RC_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WIN  = 2'd1,
        EVAL = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            first_q, first_d;   // start immediately after reset / lock loss
    logic            pend_q,  pend_d;    // period expired while a window was busy
    logic [31:0]     pcnt_q,  pcnt_d;
    logic [W_W-1:0]  w_q,     w_d;
    logic [RC_W-1:0] rc_q,    rc_d;
    logic [4:0]      e_q,     e_d;

    logic            spareleft_q, spareleft_d;
    logic            capture_q,   capture_d;
    logic            cal_done_q,  cal_done_d;
    logic [NCH-1:0]  lock_mask_q, lock_mask_d;
    logic [15:0]     cal_cnt_q,   cal_cnt_d;
    logic [15:0]     fail_cnt_q,  fail_cnt_d;

    logic [8:0]      e_sum;
    logic [4:0]      e_new;
    logic [31:0]     period_last;
    logic            expired;
    logic [NCH-1:0]  mask_now;
    logic            start_req;

    // The exponent is clamped before it is truncated. Otherwise a large
    // calibticks would wrap to a very short period.
    assign e_sum       = 9'(BASE_EXP) + {1'b0, bus.calibticks};
    assign e_new       = (e_sum > 9'd31) ? 5'd31 : e_sum[4:0];
    assign period_last = (32'd1 << e_q) - 32'd1;
    assign expired     = (pcnt_q == period_last);
    assign start_req   = first_q | pend_q | expired | bus.force_cal;

    // NOTE: every variable written in an always_comb gets a default first, so
    // no path can leave a value unassigned and infer a latch.
    always_comb begin
        mask_now = '0;
        for (int j = 0; j < NCH; j++) begin
            mask_now[j] = |bus.delaycounter[3*j +: 3];
        end
    end

    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        pend_d      = pend_q | (expired && (state_q != IDLE));
        pcnt_d      = pcnt_q + 32'd1;
        w_d         = w_q;
        rc_d        = rc_q;
        e_d         = e_q;
        lock_mask_d = lock_mask_q;
        cal_cnt_d   = cal_cnt_q;
        fail_cnt_d  = fail_cnt_q;

        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d = WIN;
                    first_d = 1'b0;
                    pend_d  = 1'b0;
                    pcnt_d  = '0;
                    w_d     = '0;
                    e_d     = e_new;
                end
            end
            WIN: begin
                if (w_q == W_LAST) begin
                    state_d = EVAL;
                end else begin
                    w_d = w_q + 1'b1;
                end
            end
            EVAL: begin
                lock_mask_d = mask_now;
                if (cal_cnt_q != 16'hFFFF) cal_cnt_d = cal_cnt_q + 16'd1;
                if (!(&mask_now)) begin
                    if (fail_cnt_q != 16'hFFFF) fail_cnt_d = fail_cnt_q + 16'd1;
                    if (rc_q < RC_MAX) begin
                        // A retry keeps pcnt running, so the periodic schedule is unchanged.
                        rc_d    = rc_q + 1'b1;
                        state_d = WIN;
                        w_d     = '0;
                    end else begin
                        rc_d    = '0;
                        state_d = IDLE;
                    end
                end else begin
                    rc_d    = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Lock loss overrides everything. The statistics are held, and the
        // next lock starts a fresh window.
        if (!bus.clk_locked) begin
            state_d     = IDLE;
            first_d     = 1'b1;
            pend_d      = 1'b0;
            pcnt_d      = '0;
            w_d         = '0;
            rc_d        = '0;
            lock_mask_d = '0;
            cal_cnt_d   = cal_cnt_q;
            fail_cnt_d  = fail_cnt_q;
        end

        // The outputs are computed from the next state, so the registered
        // outputs line up with the state register with no extra latency.
        spareleft_d = (state_d == WIN);
        capture_d   = (state_d == WIN) && (w_d > W_QUIET);
        cal_done_d  = (state_d == EVAL);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of the others.
    always_ff @(posedge clk_adc or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            first_q     <= 1'b1;
            pend_q      <= 1'b0;
            pcnt_q      <= '0;
            w_q         <= '0;
            rc_q        <= '0;
            e_q         <= 5'd31;
            spareleft_q <= 1'b0;
            capture_q   <= 1'b0;
            cal_done_q  <= 1'b0;
            lock_mask_q <= '0;
            cal_cnt_q   <= '0;
            fail_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            pend_q      <= pend_d;
            pcnt_q      <= pcnt_d;
            w_q         <= w_d;
            rc_q        <= rc_d;
            e_q         <= e_d;
            spareleft_q <= spareleft_d;
            capture_q   <= capture_d;
            cal_done_q  <= cal_done_d;
            lock_mask_q <= lock_mask_d;
            cal_cnt_q   <= cal_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign bus.spareleft  = spareleft_q;
    assign bus.capture_en = capture_q;
    assign bus.cal_done   = cal_done_q;
    assign bus.lock_mask  = lock_mask_q;
    assign bus.all_locked = &lock_mask_q;
    assign bus.cal_count  = cal_cnt_q;
    assign bus.fail_count = fail_cnt_q;

endmodule

// File: tb/tb_calib_window_scheduler.sv
// ---------------------------------------------------------------------------
// tb_calib_window_scheduler
//
// Self-checking bench for calib_window_scheduler. The DUT uses shortened
// timing parameters so that the periodic schedule fits in a short run:
// QUIET_TICKS=20, WINDOW_TICKS=66, BASE_EXP=8. With calibticks=0 the period
// is 256 cycles, and calibticks=24 clamps E to 31. Outputs are sampled on the
// falling edge of clk_adc.
// ---------------------------------------------------------------------------
module tb_calib_window_scheduler;

    localparam int NCH    = 16;
    localparam int QUIET  = 20;
    localparam int WTICKS = 66;
    localparam int PERIOD = 256;

    logic clk_adc = 1'b0;
    logic rst     = 1'b1;
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    calib_window_scheduler_if #(.NCH(NCH)) bus ();

    calib_window_scheduler #(
        .NCH(NCH), .QUIET_TICKS(QUIET), .WINDOW_TICKS(WTICKS),
        .MAX_RETRY(2), .BASE_EXP(8)
    ) dut (
        .clk_adc (clk_adc),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_adc = ~clk_adc;
    always @(posedge clk_adc) cyc <= cyc + 1;

    typedef struct {
        logic [NCH*3-1:0] dc;
        logic [NCH-1:0]   mask;
        logic             all_ok;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [NCH*3-1:0] mk(input int val, input logic [NCH-1:0] zero);
        logic [NCH*3-1:0] r;
        r = '0;
        for (int j = 0; j < NCH; j++) begin
            r[3*j +: 3] = zero[j] ? 3'd0 : 3'(val);
        end
        return r;
    endfunction

    task automatic wait_cal_done(input string name);
        int n;
        n = 0;
        @(negedge clk_adc);
        while (!bus.cal_done && n < 500) begin
            @(negedge clk_adc);
            n++;
        end
        if (!bus.cal_done) timeout(name);
    endtask

    task automatic wait_rise(input string name, output int at);
        int n;
        n = 0;
        @(negedge clk_adc);
        while (!bus.spareleft && n < 600) begin
            @(negedge clk_adc);
            n++;
        end
        if (!bus.spareleft) timeout(name);
        at = cyc;
    endtask

    task automatic pulse_force();
        bus.force_cal = 1'b1;
        @(negedge clk_adc);
        bus.force_cal = 1'b0;
    endtask

    initial begin
        int start1, start2, start3, hi, cap, n, seen;
        int exp_cal, exp_fail;

        vecs[0] = '{dc: mk(2, 16'h0000), mask: 16'hFFFF, all_ok: 1'b1};
        vecs[1] = '{dc: mk(2, 16'h0001), mask: 16'hFFFE, all_ok: 1'b0};
        vecs[2] = '{dc: mk(7, 16'h0000), mask: 16'hFFFF, all_ok: 1'b1};
        vecs[3] = '{dc: mk(1, 16'h8008), mask: 16'h7FF7, all_ok: 1'b0};
        vecs[4] = '{dc: mk(0, 16'h0000), mask: 16'h0000, all_ok: 1'b0};
        vecs[5] = '{dc: mk(3, 16'h5555), mask: 16'hAAAA, all_ok: 1'b0};
        vecs[6] = '{dc: mk(4, 16'h0000), mask: 16'hFFFF, all_ok: 1'b1};

        bus.clk_locked   = 1'b1;
        bus.calibticks   = 8'd0;
        bus.force_cal    = 1'b0;
        bus.delaycounter = mk(2, 16'h0000);

        // Reset state
        repeat (3) @(negedge clk_adc);
        check("rst spareleft",  32'(bus.spareleft),  32'd0);
        check("rst capture_en", 32'(bus.capture_en), 32'd0);
        check("rst cal_done",   32'(bus.cal_done),   32'd0);
        check("rst lock_mask",  32'(bus.lock_mask),  32'd0);
        check("rst all_locked", 32'(bus.all_locked), 32'd0);
        check("rst cal_count",  32'(bus.cal_count),  32'd0);
        check("rst fail_count", 32'(bus.fail_count), 32'd0);
        rst = 1'b0;

        // First window starts on the first edge after release
        @(negedge clk_adc);
        check("first window start", 32'(bus.spareleft), 32'd1);
        start1 = cyc;
        hi  = 1;
        cap = bus.capture_en ? 1 : 0;
        n   = 0;
        while (bus.spareleft && n < 1000) begin
            @(negedge clk_adc);
            n++;
            if (bus.spareleft)  hi++;
            if (bus.capture_en) cap++;
        end
        check("spareleft length",  32'(hi),  32'(WTICKS));
        check("capture_en length", 32'(cap), 32'(WTICKS - QUIET - 1));
        check("cal_done in EVAL",  32'(bus.cal_done), 32'd1);
        @(negedge clk_adc);
        check("cal_done one cycle",  32'(bus.cal_done),   32'd0);
        check("pass lock_mask",      32'(bus.lock_mask),  32'hFFFF);
        check("pass all_locked",     32'(bus.all_locked), 32'd1);
        check("pass cal_count",      32'(bus.cal_count),  32'd1);
        check("pass fail_count",     32'(bus.fail_count), 32'd0);

        // Channel 5 unlocked: three back-to-back windows, period preserved
        bus.delaycounter = mk(2, 16'h0020);
        wait_rise("period start 2", start2);
        check("period spacing 1", 32'(start2 - start1), 32'(PERIOD));
        for (int e = 0; e < 3; e++) begin
            wait_cal_done("retry eval");
            @(negedge clk_adc);
            check("ch5 lock_mask", 32'(bus.lock_mask), 32'hFFDF);
            check("retry gap", 32'(bus.spareleft), (e < 2) ? 32'd1 : 32'd0);
        end
        check("retry cal_count",  32'(bus.cal_count),  32'd4);
        check("retry fail_count", 32'(bus.fail_count), 32'd3);
        wait_rise("period start 3", start3);
        check("period spacing 2", 32'(start3 - start2), 32'(PERIOD));

        // Lock loss at w=30, then re-lock
        bus.delaycounter = mk(2, 16'h0000);
        repeat (30) @(negedge clk_adc);
        check("capture before drop", 32'(bus.capture_en), 32'd1);
        bus.clk_locked = 1'b0;
        @(negedge clk_adc);
        check("drop spareleft",  32'(bus.spareleft),  32'd0);
        check("drop capture_en", 32'(bus.capture_en), 32'd0);
        check("drop lock_mask",  32'(bus.lock_mask),  32'd0);
        check("drop all_locked", 32'(bus.all_locked), 32'd0);
        check("drop cal_count",  32'(bus.cal_count),  32'd4);
        check("drop fail_count", 32'(bus.fail_count), 32'd3);
        repeat (3) @(negedge clk_adc);
        check("held idle unlocked", 32'(bus.spareleft), 32'd0);
        bus.calibticks = 8'd24;
        bus.clk_locked = 1'b1;
        @(negedge clk_adc);
        check("relock start", 32'(bus.spareleft), 32'd1);
        wait_cal_done("relock eval");
        @(negedge clk_adc);
        check("relock cal_count", 32'(bus.cal_count), 32'd5);

        // Clamped exponent: no periodic restart in a short span
        seen = 0;
        repeat (300) begin
            @(negedge clk_adc);
            if (bus.spareleft) seen++;
        end
        check("clamped no restart", 32'(seen), 32'd0);
        pulse_force();
        check("force_cal start", 32'(bus.spareleft), 32'd1);
        repeat (10) @(negedge clk_adc);
        pulse_force();
        wait_cal_done("forced eval");
        @(negedge clk_adc);
        check("forced cal_count", 32'(bus.cal_count), 32'd6);
        seen = 0;
        repeat (150) begin
            @(negedge clk_adc);
            if (bus.spareleft) seen++;
        end
        check("force in WIN ignored", 32'(seen), 32'd0);

        // Table-driven evaluations
        exp_cal  = 6;
        exp_fail = 3;
        foreach (vecs[i]) begin
            bus.delaycounter = vecs[i].dc;
            pulse_force();
            wait_cal_done("vec eval");
            @(negedge clk_adc);
            check($sformatf("vec%0d lock_mask", i),  32'(bus.lock_mask),  32'(vecs[i].mask));
            check($sformatf("vec%0d all_locked", i), 32'(bus.all_locked), 32'(vecs[i].all_ok));
            if (vecs[i].all_ok) begin
                exp_cal += 1;
            end else begin
                exp_cal  += 3;
                exp_fail += 3;
                wait_cal_done("vec retry");
                wait_cal_done("vec retry");
                @(negedge clk_adc);
            end
            check($sformatf("vec%0d cal_count", i),  32'(bus.cal_count),  32'(exp_cal));
            check($sformatf("vec%0d fail_count", i), 32'(bus.fail_count), 32'(exp_fail));
            check($sformatf("vec%0d idle", i),       32'(bus.spareleft),  32'd0);
        end

        // Saturation of both counters
        force dut.cal_cnt_q  = 16'hFFFE;
        force dut.fail_cnt_q = 16'hFFFD;
        #1;
        release dut.cal_cnt_q;
        release dut.fail_cnt_q;
        bus.delaycounter = mk(2, 16'h0020);
        pulse_force();
        wait_cal_done("sat eval");
        @(negedge clk_adc);
        check("sat cal_count 1",  32'(bus.cal_count),  32'hFFFF);
        check("sat fail_count 1", 32'(bus.fail_count), 32'hFFFE);
        wait_cal_done("sat retry");
        wait_cal_done("sat retry");
        @(negedge clk_adc);
        check("sat cal_count 3",  32'(bus.cal_count),  32'hFFFF);
        check("sat fail_count 3", 32'(bus.fail_count), 32'hFFFF);

        // Asynchronous reset in the middle of a window
        pulse_force();
        repeat (30) @(negedge clk_adc);
        check("pre-rst capture_en", 32'(bus.capture_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst spareleft",  32'(bus.spareleft),  32'd0);
        check("async rst capture_en", 32'(bus.capture_en), 32'd0);
        check("async rst lock_mask",  32'(bus.lock_mask),  32'd0);
        check("async rst cal_count",  32'(bus.cal_count),  32'd0);
        check("async rst fail_count", 32'(bus.fail_count), 32'd0);
        @(negedge clk_adc);
        rst = 1'b0;
        @(negedge clk_adc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
